// File: rtl/channel_capture_seq.sv
// rtl/channel_capture_seq.sv - capture sequencer filling eight read-only channel words from the ADC back-end
//
// Walks the channels enabled in trigger_channel_mask on a capture command,
// fetching one conversion result per channel over a req/valid handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   trigger_channel_mask     channel enables, latched at start
//   instruction[0]           capture command (rising edge starts a scan)
//   mode[0]                  continuous scanning
//   mode[1]                  zero disabled channels at start
//   adc_req, adc_ch          request a result for channel adc_ch
//   adc_valid, adc_data      result handshake from the ADC back-end
//   ch0..ch7                 channel holding registers
//   busy, done, err_mask     status: active, sticky completion, per-channel timeout
module channel_capture_seq #(
    parameter int DATA_W  = 50,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        trigger_channel_mask,
    input  logic [7:0]        instruction,
    input  logic [7:0]        mode,
    output logic              adc_req,
    output logic [2:0]        adc_ch,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] ch0,
    output logic [DATA_W-1:0] ch1,
    output logic [DATA_W-1:0] ch2,
    output logic [DATA_W-1:0] ch3,
    output logic [DATA_W-1:0] ch4,
    output logic [DATA_W-1:0] ch5,
    output logic [DATA_W-1:0] ch6,
    output logic [DATA_W-1:0] ch7,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Last counter value before a request is abandoned; REQ then spans TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    logic [2:0]        idx_q;
    logic [7:0]        mask_q;
    logic              instr_q;
    logic [7:0]        cnt_q;
    logic              done_q;
    logic [7:0]        err_q;
    logic [DATA_W-1:0] ch_q [0:7];

    logic start;
    logic unused_bits;

    assign start       = instruction[0] & ~instr_q;
    assign unused_bits = ^{instruction[7:1], mode[7:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            mask_q  <= 8'd0;
            instr_q <= 1'b0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            instr_q <= instruction[0];
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mask_q <= trigger_channel_mask;
                        idx_q  <= 3'd0;
                        done_q <= 1'b0;
                        err_q  <= 8'd0;
                        // Clear-on-start acts on the mask being latched this same edge.
                        for (int i = 0; i < 8; i++) begin
                            if (mode[1] && !trigger_channel_mask[i]) begin
                                ch_q[i] <= '0;
                            end
                        end
                        state_q <= (trigger_channel_mask == 8'd0) ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (mask_q[idx_q]) begin
                        cnt_q   <= 8'd0;
                        state_q <= ST_REQ;
                    end else if (idx_q == 3'd7) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_REQ: begin
                    // A valid arriving on the timeout edge wins over the timeout.
                    if (adc_valid || cnt_q == TMO_LAST) begin
                        if (adc_valid) begin
                            ch_q[idx_q] <= adc_data;
                        end else begin
                            ch_q[idx_q]  <= '1;
                            err_q[idx_q] <= 1'b1;
                        end
                        if (idx_q == 3'd7) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= ST_SCAN;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    if (mode[0]) begin
                        idx_q   <= 3'd0;
                        state_q <= ST_SCAN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Decoded from registered state only, so these cannot glitch between cycles.
    assign busy     = (state_q != ST_IDLE);
    assign adc_req  = (state_q == ST_REQ);
    assign adc_ch   = idx_q;
    assign done     = done_q;
    assign err_mask = err_q;

    assign ch0 = ch_q[0];
    assign ch1 = ch_q[1];
    assign ch2 = ch_q[2];
    assign ch3 = ch_q[3];
    assign ch4 = ch_q[4];
    assign ch5 = ch_q[5];
    assign ch6 = ch_q[6];
    assign ch7 = ch_q[7];

endmodule

// File: tb/tb_channel_capture_seq.sv
// tb/tb_channel_capture_seq.sv - self-checking bench for channel_capture_seq
module tb_channel_capture_seq;

    localparam logic [49:0] BASE1 = 50'h2D2D2D2D2D2D3;
    localparam logic [49:0] ONES  = 50'h3FFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  trigger_channel_mask = 8'd0;
    logic [7:0]  instruction = 8'd0;
    logic [7:0]  mode = 8'd0;
    logic        adc_req;
    logic [2:0]  adc_ch;
    logic        adc_valid;
    logic [49:0] adc_data;
    logic [49:0] ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
    logic        busy;
    logic        done;
    logic [7:0]  err_mask;

    int total = 0;
    int bad = 0;

    // ADC responder controls
    logic        adc_answer = 1'b1;
    int          adc_k = 0;
    logic [49:0] base = BASE1;

    // scoreboard: expected captures pushed when the responder drives a valid
    logic [2:0]  sb_ch [$];
    logic [49:0] sb_data [$];
    logic [2:0]  got_req [$];
    int          got_len [$];
    logic [49:0] exp_ch [8];
    logic        exp_vld [8];

    always #5 clk = ~clk;

    channel_capture_seq #(.DATA_W(50), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .trigger_channel_mask(trigger_channel_mask),
        .instruction(instruction), .mode(mode),
        .adc_req(adc_req), .adc_ch(adc_ch),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .ch4(ch4), .ch5(ch5), .ch6(ch6), .ch7(ch7),
        .busy(busy), .done(done), .err_mask(err_mask)
    );

    initial begin
        logic req_prev;
        int   wait_n;
        req_prev  = 1'b0;
        wait_n    = 0;
        adc_valid = 1'b0;
        adc_data  = '0;
        forever begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (adc_req === 1'b1) begin
                if (!req_prev) begin
                    got_req.push_back(adc_ch);
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
                if (adc_answer && wait_n == adc_k) begin
                    adc_valid = 1'b1;
                    adc_data  = base + 50'(adc_ch);
                    sb_ch.push_back(adc_ch);
                    sb_data.push_back(base + 50'(adc_ch));
                end
                req_prev = 1'b1;
            end else begin
                if (req_prev) got_len.push_back(wait_n + 1);
                req_prev = 1'b0;
            end
        end
    end

    function automatic logic [49:0] get_ch(int c);
        case (c)
            0: return ch0;
            1: return ch1;
            2: return ch2;
            3: return ch3;
            4: return ch4;
            5: return ch5;
            6: return ch6;
            default: return ch7;
        endcase
    endfunction

    task automatic clear_logs();
        got_req.delete();
        got_len.delete();
        sb_ch.delete();
        sb_data.delete();
    endtask

    // Pops the scoreboard into the latest expected value per channel.
    task automatic drain_sb();
        for (int i = 0; i < 8; i++) exp_vld[i] = 1'b0;
        while (sb_ch.size() > 0) begin
            logic [2:0] c;
            c = sb_ch.pop_front();
            exp_ch[c]  = sb_data.pop_front();
            exp_vld[c] = 1'b1;
        end
    endtask

    task automatic do_start(input logic [7:0] m);
        @(negedge clk);
        trigger_channel_mask = m;
        instruction = 8'd1;
        @(negedge clk);
        instruction = 8'd0;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, adc_req, adc_ch, done, err_mask} !== 14'd0) begin
            bad++;
            $display("FAIL reset_status got=%h want=0", {busy, adc_req, adc_ch, done, err_mask});
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (get_ch(i) !== 50'd0) begin
                bad++;
                $display("FAIL reset_ch%0d got=%h want=0", i, get_ch(i));
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_scan();
        int cyc;
        clear_logs();
        mode = 8'd0; adc_answer = 1'b1; adc_k = 0; base = BASE1;
        do_start(8'hFF);
        count_busy(cyc);
        total++;
        if (cyc !== 17) begin bad++; $display("FAIL full_busy_len got=%0d want=17", cyc); end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b want=1", done); end
        total++;
        if (err_mask !== 8'h00) begin bad++; $display("FAIL full_err got=%h want=00", err_mask); end
        total++;
        if (sb_ch.size() !== 8) begin bad++; $display("FAIL full_sb_count got=%0d want=8", sb_ch.size()); end
        drain_sb();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (!exp_vld[i] || get_ch(i) !== BASE1 + 50'(i)) begin
                bad++;
                $display("FAIL full_ch%0d got=%h want=%h", i, get_ch(i), BASE1 + 50'(i));
            end
            total++;
            if (get_ch(i) !== exp_ch[i]) begin
                bad++;
                $display("FAIL full_sb_ch%0d got=%h want=%h", i, get_ch(i), exp_ch[i]);
            end
        end
    endtask

    task automatic test_clear_on_start();
        int cyc;
        clear_logs();
        mode = 8'd0; adc_k = 1; base = 50'h1111_0000_0000;
        do_start(8'h02);
        count_busy(cyc);
        total++;
        if (ch1 !== 50'h1111_0000_0001) begin bad++; $display("FAIL preload_ch1 got=%h want=%h", ch1, 50'h1111_0000_0001); end
        clear_logs();
        mode = 8'd2; adc_k = 2; base = 50'h2222_0000_0000;
        do_start(8'h05);
        count_busy(cyc);
        total++;
        if (got_req.size() !== 2 || got_req[0] !== 3'd0 || got_req[1] !== 3'd2) begin
            bad++;
            $display("FAIL clr_req_order got_n=%0d first=%0d second=%0d want 0,2", got_req.size(),
                     got_req.size() > 0 ? got_req[0] : 3'd7, got_req.size() > 1 ? got_req[1] : 3'd7);
        end
        total++;
        if (ch1 !== 50'd0) begin bad++; $display("FAIL clr_ch1 got=%h want=0", ch1); end
        total++;
        if (ch3 !== 50'd0) begin bad++; $display("FAIL clr_ch3 got=%h want=0", ch3); end
        total++;
        if (cyc !== 8 + 3 + 3 + 1) begin bad++; $display("FAIL clr_busy_len got=%0d want=15", cyc); end
        drain_sb();
        total++;
        if (!exp_vld[0] || ch0 !== exp_ch[0]) begin bad++; $display("FAIL clr_ch0 got=%h want=%h", ch0, exp_ch[0]); end
        total++;
        if (!exp_vld[2] || ch2 !== exp_ch[2]) begin bad++; $display("FAIL clr_ch2 got=%h want=%h", ch2, exp_ch[2]); end
        mode = 8'd0;
    endtask

    task automatic test_timeout();
        int cyc;
        clear_logs();
        adc_answer = 1'b0;
        do_start(8'h08);
        count_busy(cyc);
        @(negedge clk);
        total++;
        if (got_len.size() !== 1 || got_len[0] !== 255) begin
            bad++;
            $display("FAIL tmo_req_len got=%0d want=255", got_len.size() > 0 ? got_len[0] : -1);
        end
        total++;
        if (cyc !== 8 + 255 + 1) begin bad++; $display("FAIL tmo_busy_len got=%0d want=264", cyc); end
        total++;
        if (ch3 !== ONES) begin bad++; $display("FAIL tmo_ch3 got=%h want=%h", ch3, ONES); end
        total++;
        if (err_mask !== 8'h08) begin bad++; $display("FAIL tmo_err got=%h want=08", err_mask); end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL tmo_done got=%b want=1", done); end
        adc_answer = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        clear_logs();
        adc_k = 3; base = 50'h3333_0000_0000;
        do_start(8'h81);
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            if (cyc == 3) begin trigger_channel_mask = 8'h00; instruction = 8'd1; end
            if (cyc == 5) instruction = 8'd0;
            @(negedge clk);
        end
        total++;
        if (cyc !== 17) begin bad++; $display("FAIL b2b_busy_len got=%0d want=17", cyc); end
        total++;
        if (got_req.size() !== 2 || got_req[0] !== 3'd0 || got_req[1] !== 3'd7) begin
            bad++;
            $display("FAIL b2b_req_order got_n=%0d want 0,7", got_req.size());
        end
        repeat (6) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_extra_scan busy=%b want=0", busy); end
        drain_sb();
        total++;
        if (!exp_vld[7] || ch7 !== exp_ch[7]) begin bad++; $display("FAIL b2b_ch7 got=%h want=%h", ch7, exp_ch[7]); end
    endtask

    task automatic test_continuous();
        int   cyc;
        logic busy_drop;
        logic done_drop;
        clear_logs();
        adc_k = 0; base = 50'h4444_0000_0000; mode = 8'd1;
        do_start(8'h01);
        busy_drop = 1'b0;
        done_drop = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (busy !== 1'b1) busy_drop = 1'b1;
            if (i >= 12 && done !== 1'b1) done_drop = 1'b1;
            @(negedge clk);
        end
        total++;
        if (busy_drop) begin bad++; $display("FAIL cont_busy_held got=dropped want=held"); end
        total++;
        if (done_drop) begin bad++; $display("FAIL cont_done_held got=dropped want=held"); end
        total++;
        if (got_req.size() < 3) begin bad++; $display("FAIL cont_rescans got=%0d want>=3", got_req.size()); end
        mode = 8'd0;
        count_busy(cyc);
        total++;
        if (cyc > 12) begin bad++; $display("FAIL cont_stop_latency got=%0d want<=12", cyc); end
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL cont_stop_idle busy=%b done=%b want busy=0 done=1", busy, done);
        end
        drain_sb();
        total++;
        if (!exp_vld[0] || ch0 !== exp_ch[0]) begin bad++; $display("FAIL cont_ch0 got=%h want=%h", ch0, exp_ch[0]); end
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        int guard;
        clear_logs();
        adc_answer = 1'b0;
        do_start(8'h10);
        guard = 0;
        while (!(adc_req === 1'b1 && adc_ch === 3'd4) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        total++;
        if (guard >= 100) begin bad++; $display("FAIL rstmid_reach_req got=timeout want=req_ch4"); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({busy, adc_req, adc_ch, done, err_mask} !== 14'd0) begin
            bad++;
            $display("FAIL rstmid_status got=%h want=0", {busy, adc_req, adc_ch, done, err_mask});
        end
        total++;
        if ({ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7} !== 400'd0) begin
            bad++;
            $display("FAIL rstmid_channels got=nonzero want=0");
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        adc_answer = 1'b1; adc_k = 2; base = 50'h5555_0000_0000;
        do_start(8'h10);
        count_busy(cyc);
        total++;
        if (ch4 !== 50'h5555_0000_0004) begin bad++; $display("FAIL rstmid_ch4 got=%h want=%h", ch4, 50'h5555_0000_0004); end
        total++;
        if (got_req.size() !== 1 || got_req[0] !== 3'd4) begin bad++; $display("FAIL rstmid_req got_n=%0d want one req ch4", got_req.size()); end
        total++;
        if (cyc !== 8 + 3 + 1) begin bad++; $display("FAIL rstmid_busy_len got=%0d want=12", cyc); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_clear_on_start();
        test_timeout();
        test_back_to_back();
        test_continuous();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
